avm_uart_word_reader: RTL and testbench

Avalon-MM master that polls the UART core's status register, drains received bytes, and assembles every BYTES_PER_WORD bytes into one word. Completed words are buffered in an output FIFO and presented on a valid/ready stream to the downstream consumer. It is the parametrised successor of the single-byte RX poller, adding multi-byte assembly, configurable byte order, buffering with back-pressure, and flush.

---
 rtl/avm_uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 90 +++++++++
 rtl/avm_uart_word_reader.sv | 184 ++++++++++++++++++
 tb/tb_avm_uart_word_reader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avm_uart_pkg.sv
// ---------------------------------------------------------------------------
// avm_uart_pkg
// Shared definitions for talking to the UART core over Avalon-MM:
// register map offsets, status bit positions, and the poller FSM states.
// ---------------------------------------------------------------------------
package avm_uart_pkg;

    // UART core register map (word-aligned byte offsets on a 5-bit bus)
    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    // Status register bit positions
    localparam int TX_OK_BIT = 6;
    localparam int RX_OK_BIT = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUERY = 2'd1,
        S_READ  = 2'd2
    } state_t;

    // True when the status word reports a received byte waiting
    function automatic logic rx_ready(input logic [31:0] status);
        return status[RX_OK_BIT];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. head_data always presents the oldest entry
// (zero while empty). clear empties the FIFO and wins over push/pop.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous empty request
//   push         write push_data (caller guarantees the FIFO is not full)
//   push_data    WIDTH-bit entry to write
//   pop          drop the head entry (ignored when empty)
//   head_data    oldest entry, show-ahead
//   count        occupied entries, 0..DEPTH
//   empty, full  occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // Zero while empty so a stale entry never leaks onto the output
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !clear;
        do_pop   = pop && !empty && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_data is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // The writer gates its requests on free space; a push into a full FIFO
    // would silently overwrite the head.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && !clear && full)
    ) else $error("sync_fifo: push while full");

endmodule

// File: rtl/avm_uart_word_reader.sv
// ---------------------------------------------------------------------------
// avm_uart_word_reader
// Avalon-MM master that polls the UART status register, reads each received
// byte, packs BYTES_PER_WORD bytes into a word and queues finished words in
// a show-ahead FIFO presented as a valid/ready stream.
//
// Ports:
//   avm_clk, avm_rst_n   clock, asynchronous active-low reset
//   avm_address/read     registered Avalon read request
//   avm_readdata         Avalon read data
//   avm_waitrequest      Avalon stall; transfer completes when read & !wait
//   flush                drop the partial word and empty the FIFO
//   word_data/valid      FIFO head word and non-empty flag
//   word_ready           consumer accepts the head word
//   fifo_count           occupied FIFO entries
//   partial_bytes        bytes gathered toward the current word
// ---------------------------------------------------------------------------
module avm_uart_word_reader
    import avm_uart_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int BIG_ENDIAN     = 1
) (
    input  logic                                  avm_clk,
    input  logic                                  avm_rst_n,
    output logic [4:0]                            avm_address,
    output logic                                  avm_read,
    input  logic [31:0]                           avm_readdata,
    input  logic                                  avm_waitrequest,
    input  logic                                  flush,
    output logic [8*BYTES_PER_WORD-1:0]           word_data,
    output logic                                  word_valid,
    input  logic                                  word_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]   partial_bytes
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
    localparam int PB_W   = $clog2(BYTES_PER_WORD+1);

    state_t            state_q,      state_d;
    logic              avm_read_q,   avm_read_d;
    logic [4:0]        avm_address_q, avm_address_d;
    logic              flush_pend_q, flush_pend_d;
    logic [WORD_W-1:0] acc_q,        acc_d;
    logic [PB_W-1:0]   partial_q,    partial_d;

    logic              xfer_done;
    logic              drop;
    logic              byte_take;
    logic              word_done;
    logic [7:0]        rx_byte;
    logic [WORD_W-1:0] word_next;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              unused_rd_hi;

    assign xfer_done = avm_read_q && !avm_waitrequest;
    // A flush seen at any point of an in-flight transfer spoils its data
    assign drop      = flush || flush_pend_q;
    assign byte_take = (state_q == S_READ) && xfer_done && !drop;
    assign word_done = byte_take && (partial_q == PB_W'(BYTES_PER_WORD-1));
    assign rx_byte   = avm_readdata[7:0];
    assign unused_rd_hi = ^{avm_readdata[31:8], fifo_full};

    // ---------------- poller FSM ----------------
    always_comb begin
        state_d       = state_q;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        flush_pend_d  = flush_pend_q;
        case (state_q)
            S_IDLE: begin
                flush_pend_d = 1'b0;
                // Back-pressure: only poll when the FIFO can take a word
                if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
                    avm_read_d    = 1'b1;
                    avm_address_d = STATUS_BASE;
                    state_d       = S_QUERY;
                end else begin
                    avm_read_d = 1'b0;
                end
            end
            S_QUERY: begin
                if (xfer_done) begin
                    flush_pend_d = 1'b0;
                    if (!drop && rx_ready(avm_readdata)) begin
                        avm_address_d = RX_BASE;
                        state_d       = S_READ;
                    end else begin
                        avm_read_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            S_READ: begin
                if (xfer_done) begin
                    flush_pend_d = 1'b0;
                    avm_read_d   = 1'b0;
                    state_d      = S_IDLE;
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                avm_read_d    = 1'b0;
                avm_address_d = STATUS_BASE;
                flush_pend_d  = 1'b0;
            end
        endcase
    end

    // ---------------- word assembly ----------------
    always_comb begin
        word_next = acc_q;
        if (byte_take) begin
            if (BIG_ENDIAN != 0) begin
                word_next = (acc_q << 8) | WORD_W'(rx_byte);
            end else begin
                for (int i = 0; i < BYTES_PER_WORD; i++) begin
                    if (partial_q == PB_W'(i)) word_next[i*8 +: 8] = rx_byte;
                end
            end
        end

        acc_d     = word_done ? '0 : word_next;
        partial_d = partial_q;
        if (byte_take) partial_d = word_done ? '0 : partial_q + PB_W'(1);

        if (flush) begin
            acc_d     = '0;
            partial_d = '0;
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state_q       <= S_IDLE;
            avm_read_q    <= 1'b0;
            avm_address_q <= STATUS_BASE;
            flush_pend_q  <= 1'b0;
            acc_q         <= '0;
            partial_q     <= '0;
        end else begin
            state_q       <= state_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            flush_pend_q  <= flush_pend_d;
            acc_q         <= acc_d;
            partial_q     <= partial_d;
        end
    end

    // ---------------- output FIFO ----------------
    assign fifo_pop = word_valid && word_ready;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (avm_clk),
        .rst_n     (avm_rst_n),
        .clear     (flush),
        .push      (word_done),
        .push_data (word_next),
        .pop       (fifo_pop),
        .head_data (word_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign word_valid    = !fifo_empty;
    assign avm_read      = avm_read_q;
    assign avm_address   = avm_address_q;
    assign partial_bytes = partial_q;

endmodule

// File: tb/tb_avm_uart_word_reader.sv
module tb_avm_uart_word_reader;

    localparam int BPW   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rdata;
    logic        wreq;
    logic        flush;
    logic        word_ready;

    logic [4:0]  be_addr, le_addr;
    logic        be_read, le_read;
    logic [31:0] be_data, le_data;
    logic        be_valid, le_valid;
    logic [3:0]  be_count, le_count;
    logic [2:0]  be_partial, le_partial;

    always #5 clk = ~clk;

    avm_uart_word_reader #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1)) dut_be (
        .avm_clk(clk), .avm_rst_n(rst_n), .avm_address(be_addr), .avm_read(be_read),
        .avm_readdata(rdata), .avm_waitrequest(wreq), .flush(flush),
        .word_data(be_data), .word_valid(be_valid), .word_ready(word_ready),
        .fifo_count(be_count), .partial_bytes(be_partial)
    );

    // Little-endian twin; it sees the same bus responses and must issue the
    // same requests cycle for cycle.
    avm_uart_word_reader #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .BIG_ENDIAN(0)) dut_le (
        .avm_clk(clk), .avm_rst_n(rst_n), .avm_address(le_addr), .avm_read(le_read),
        .avm_readdata(rdata), .avm_waitrequest(wreq), .flush(flush),
        .word_data(le_data), .word_valid(le_valid), .word_ready(word_ready),
        .fifo_count(le_count), .partial_bytes(le_partial)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // UART slave model state
    logic [7:0]  rx_q[$];
    logic [31:0] got_be[$];
    logic [31:0] got_le[$];
    int          wait_st = 0;
    int          wait_rx = 0;
    int          skip    = 0;
    int          cnt     = 0;
    bit          diverged = 0;

    typedef struct {
        logic [31:0] bytes_in;   // first byte in [31:24]
        int          wst;
        int          wrx;
        int          skp;
        logic [31:0] exp_be;
        logic [31:0] exp_le;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input string name, input int n);
        int t;
        t = 0;
        while (!(got_be.size() >= n && got_le.size() >= n) && t < 3000) begin
            tick();
            t++;
        end
        check({name, "_words_arrived"}, (got_be.size() >= n && got_le.size() >= n), 1);
    endtask

    task automatic wait_rx_read(input string name);
        int t;
        t = 0;
        while (!(be_read && be_addr == 5'd0) && t < 500) begin
            tick();
            t++;
        end
        check({name, "_reached_read"}, (be_read && be_addr == 5'd0), 1);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) rx_q.push_back(w[31-8*i -: 8]);
    endtask

    // Avalon slave + stream monitor; drives at the falling edge so values are
    // stable at the rising edge the DUT samples.
    initial begin
        wreq  = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (le_read !== be_read || le_addr !== be_addr) diverged = 1;
            if (be_valid && word_ready) got_be.push_back(be_data);
            if (le_valid && word_ready) got_le.push_back(le_data);
            if (!rst_n || !be_read) begin
                wreq = 1'b0;
                cnt  = 0;
            end else if (cnt < ((be_addr == 5'd8) ? wait_st : wait_rx)) begin
                wreq = 1'b1;
                cnt++;
            end else begin
                wreq = 1'b0;
                cnt  = 0;
                if (be_addr == 5'd8) begin
                    if (skip > 0) begin
                        skip--;
                        rdata = 32'h0000_0000;
                    end else if (rx_q.size() > 0) begin
                        rdata = 32'h5A5A_5AC0;
                    end else begin
                        rdata = 32'hFFFF_FF7F;   // everything but RX_OK set
                    end
                end else begin
                    if (rx_q.size() > 0) rdata = {24'hA5A5A5, rx_q.pop_front()};
                    else                 rdata = 32'hDEAD_BE00;
                end
            end
        end
    end

    initial begin
        int bad;
        int t;
        bit seen;
        logic [31:0] exp_w;

        vecs[0] = '{32'h1122_3344, 2, 2, 2, 32'h1122_3344, 32'h4433_2211};
        vecs[1] = '{32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 32'hEFBE_ADDE};
        vecs[2] = '{32'h00FF_00FF, 1, 3, 1, 32'h00FF_00FF, 32'hFF00_FF00};
        vecs[3] = '{32'h8001_7FFE, 3, 0, 0, 32'h8001_7FFE, 32'hFE7F_0180};

        rst_n      = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b1;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_read",    be_read,    0);
        check("rst_addr",    be_addr,    8);
        check("rst_valid",   be_valid,   0);
        check("rst_count",   be_count,   0);
        check("rst_partial", be_partial, 0);
        check("rst_data",    be_data,    0);
        check("rst_le_data", le_data,    0);

        // Release between edges; the cycle up to the next edge is the S_IDLE
        // cycle, and the status read appears at the end of it.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_read_low", be_read, 0);
        tick();
        check("first_poll_read", be_read, 1);
        check("first_poll_addr", be_addr, 8);

        // ---- table-driven word assembly ----
        for (int i = 0; i < 4; i++) begin
            got_be.delete();
            got_le.delete();
            wait_st = vecs[i].wst;
            wait_rx = vecs[i].wrx;
            skip    = vecs[i].skp;
            push_word(vecs[i].bytes_in);
            wait_words($sformatf("vec%0d", i), 1);
            if (got_be.size() > 0) check($sformatf("vec%0d_be", i), got_be[0], vecs[i].exp_be);
            if (got_le.size() > 0) check($sformatf("vec%0d_le", i), got_le[0], vecs[i].exp_le);
            check($sformatf("vec%0d_partial", i), be_partial, 0);
        end

        // ---- back-pressure: fill FIFO, polling stops, drain in order ----
        wait_st = 0;
        wait_rx = 0;
        repeat (5) tick();
        got_be.delete();
        got_le.delete();
        word_ready = 1'b0;
        for (int k = 0; k < 36; k++) rx_q.push_back(8'h10 + 8'(k));
        t = 0;
        while (be_count != 4'd8 && t < 2000) begin
            tick();
            t++;
        end
        check("bp_count_full", be_count, 8);
        check("bp_le_count_full", le_count, 8);
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (be_read) seen = 1;
        end
        check("bp_read_held_low", seen, 0);
        check("bp_bytes_left_in_uart", rx_q.size(), 4);
        check("bp_partial", be_partial, 0);
        word_ready = 1'b1;
        wait_words("bp", 9);
        for (int w = 0; w < 9; w++) begin
            exp_w = {8'h10 + 8'(4*w), 8'h11 + 8'(4*w), 8'h12 + 8'(4*w), 8'h13 + 8'(4*w)};
            if (got_be.size() > w) check($sformatf("bp_be_word%0d", w), got_be[w], exp_w);
            exp_w = {8'h13 + 8'(4*w), 8'h12 + 8'(4*w), 8'h11 + 8'(4*w), 8'h10 + 8'(4*w)};
            if (got_le.size() > w) check($sformatf("bp_le_word%0d", w), got_le[w], exp_w);
        end

        // ---- waitrequest held 5 cycles in S_READ ----
        wait_rx = 5;
        rx_q.push_back(8'hC1);
        wait_rx_read("hold");
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (!(be_read && be_addr == 5'd0 && be_partial == 3'd0)) bad++;
        end
        check("hold_stable_cycles", bad, 0);
        tick();
        check("hold_read_released", be_read, 0);
        check("hold_partial_incr", be_partial, 1);

        // ---- flush after 2 bytes ----
        wait_rx = 0;
        rx_q.push_back(8'hC2);
        t = 0;
        while (be_partial != 3'd2 && t < 200) begin
            tick();
            t++;
        end
        check("flush2_partial_before", be_partial, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush2_partial_cleared", be_partial, 0);
        check("flush2_le_partial_cleared", le_partial, 0);
        got_be.delete();
        got_le.delete();
        push_word(32'h3132_3334);
        wait_words("flush2", 1);
        if (got_be.size() > 0) check("flush2_fresh_be", got_be[0], 32'h3132_3334);
        if (got_le.size() > 0) check("flush2_fresh_le", got_le[0], 32'h3433_3231);

        // ---- flush while S_READ is stalled ----
        wait_rx = 4;
        rx_q.push_back(8'hEE);
        wait_rx_read("flushrd");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flushrd_read_held", be_read, 1);
        t = 0;
        while (be_read && t < 20) begin
            tick();
            t++;
        end
        check("flushrd_read_completed", be_read, 0);
        check("flushrd_byte_consumed", rx_q.size(), 0);
        check("flushrd_partial_zero", be_partial, 0);
        check("flushrd_no_word", be_valid, 0);
        wait_rx = 0;
        got_be.delete();
        got_le.delete();
        push_word(32'h5152_5354);
        wait_words("flushrd", 1);
        if (got_be.size() > 0) check("flushrd_next_be", got_be[0], 32'h5152_5354);
        if (got_le.size() > 0) check("flushrd_next_le", got_le[0], 32'h5453_5251);

        // ---- asynchronous reset mid-S_READ with 3 words buffered ----
        word_ready = 1'b0;
        for (int k = 0; k < 12; k++) rx_q.push_back(8'h60 + 8'(k));
        t = 0;
        while (be_count != 4'd3 && t < 1000) begin
            tick();
            t++;
        end
        check("arst_count_before", be_count, 3);
        wait_rx = 6;
        rx_q.push_back(8'h99);
        wait_rx_read("arst");
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_read",    be_read,    0);
        check("arst_addr",    be_addr,    8);
        check("arst_valid",   be_valid,   0);
        check("arst_count",   be_count,   0);
        check("arst_partial", be_partial, 0);
        check("arst_data",    be_data,    0);
        check("arst_le_count", le_count,  0);
        rx_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        check("bus_lockstep", diverged, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
